msp430_reset_sequencer: RTL and testbench

Parametrised multi-domain reset controller: a successor to the two-flop reset synchronizer.
- Takes CHANNELS asynchronous reset requests and synchronizes each through a SYNC_DEPTH-stage chain.
- Propagates each request hierarchically: a request on channel k resets k and every higher-index channel.
- Stretches the reset to a minimum width, then releases channels one at a time in ascending order with a programmable gap.
- Sits at the system top, driving per-domain synchronous resets: CPU core, peripherals, debug, and so on.

---
 rtl/msp430_reset_pkg.sv | 33 +++
 rtl/msp430_reset_sequencer_sync.sv | 24 ++
 rtl/msp430_reset_sequencer.sv | 125 ++++++++++++
 tb/tb_msp430_reset_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/msp430_reset_pkg.sv
// Shared types and mask helpers for the reset sequencer.
// Holds the FSM state enum plus prefix / lowest-bit functions.
package msp430_reset_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_STRETCH,
    ST_RELEASE,
    ST_WAIT
  } reset_state_t;

  // m[j] = OR of v[0..j]: a request on k covers k and above.
  function automatic logic [MAX_CH-1:0] prefix_mask(
    input logic [MAX_CH-1:0] v
  );
    logic [MAX_CH-1:0] m;
    m[0] = v[0];
    for (int i = 1; i < MAX_CH; i++) begin
      m[i] = m[i-1] | v[i];
    end
    return m;
  endfunction

  function automatic logic [MAX_CH-1:0] clear_lowest(
    input logic [MAX_CH-1:0] v
  );
    return v & (v - MAX_CH'(1));
  endfunction

endpackage

// File: rtl/msp430_reset_sequencer_sync.sv
// Single-bit synchronizer chain, forced to 1 while rst is high.
// Ports: clk, rst, d (async in), q (last stage).
module msp430_sync_cell #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/msp430_reset_sequencer.sv
// Multi-domain reset sequencer: sync, stretch, ordered release.
// Ports: clk, rst, rst_req_a -> rst_s, seq_busy, seq_done.
module msp430_reset_sequencer
  import msp430_reset_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int STRETCH    = 16,
  parameter int GAP        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] rst_req_a,
  output logic [CHANNELS-1:0] rst_s,
  output logic                seq_busy,
  output logic                seq_done
);

  localparam int LIMIT = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CW    = $clog2(LIMIT + 1);

  localparam logic [CW-1:0] STR_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  logic [CHANNELS-1:0] req_sync;
  logic [MAX_CH-1:0]   pmask_full;
  logic [MAX_CH-1:0]   clr_full;
  logic [CHANNELS-1:0] pmask;
  logic [CHANNELS-1:0] amask_clr;
  logic                unused_hi;

  reset_state_t        state, state_n;
  logic [CHANNELS-1:0] amask, amask_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                done_n;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    msp430_sync_cell #(
      .SYNC_DEPTH(SYNC_DEPTH)
    ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (rst_req_a[g]),
      .q  (req_sync[g])
    );
  end

  assign pmask_full = prefix_mask(MAX_CH'(req_sync));
  assign clr_full   = clear_lowest(MAX_CH'(amask));
  assign pmask      = pmask_full[CHANNELS-1:0];
  assign amask_clr  = clr_full[CHANNELS-1:0];
  assign unused_hi  = ^{pmask_full, clr_full};

  always_comb begin
    state_n = state;
    amask_n = amask;
    cnt_n   = cnt;
    done_n  = 1'b0;
    // A live request beats everything, including a release
    // scheduled for this same edge.
    if (pmask != '0) begin
      amask_n = amask | pmask;
      state_n = ST_HOLD;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          amask_n = '0;
        end
        ST_HOLD: begin
          state_n = ST_STRETCH;
          cnt_n   = '0;
        end
        ST_STRETCH: begin
          if (cnt == STR_LAST) begin
            state_n = ST_RELEASE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          amask_n = amask_clr;
          if (amask_clr == '0) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = '0;
          end
        end
        ST_WAIT: begin
          if (cnt == GAP_LAST) begin
            state_n = ST_RELEASE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = ST_HOLD;
          amask_n = '1;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HOLD;
      amask    <= '1;
      cnt      <= '0;
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
    end else begin
      state    <= state_n;
      amask    <= amask_n;
      cnt      <= cnt_n;
      seq_busy <= |amask_n;
      seq_done <= done_n;
    end
  end

  assign rst_s = amask;

endmodule

// File: tb/tb_msp430_reset_sequencer.sv
// Self-checking bench for msp430_reset_sequencer.
// CHANNELS=4, SYNC_DEPTH=2, STRETCH=4, GAP=2.
module tb_msp430_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rst_req_a;
  logic [3:0] rst_s;
  logic       seq_busy;
  logic       seq_done;

  always #5 clk = ~clk;

  msp430_reset_sequencer #(
    .CHANNELS  (4),
    .SYNC_DEPTH(2),
    .STRETCH   (4),
    .GAP       (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rst_req_a(rst_req_a),
    .rst_s    (rst_s),
    .seq_busy (seq_busy),
    .seq_done (seq_done)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] rs;
    logic       done;
  } vec_t;

  vec_t tab [64];
  int   nv;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input int i, input logic r,
                     input logic [3:0] q,
                     input logic [3:0] rs,
                     input logic d);
    tab[i].rst  = r;
    tab[i].req  = q;
    tab[i].rs   = rs;
    tab[i].done = d;
  endtask

  // Power-up release schedule, e = edges since rst fell.
  function automatic logic [3:0] pu(input int e);
    if (e < 8)  return 4'b1111;
    if (e < 11) return 4'b1110;
    if (e < 14) return 4'b1100;
    if (e < 17) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic run_table(input string name);
    for (int i = 0; i < nv; i++) begin
      rst       = tab[i].rst;
      rst_req_a = tab[i].req;
      tick();
      chk({name, " rst_s"}, i + 1, 32'(rst_s),
          32'(tab[i].rs));
      chk({name, " busy"}, i + 1, 32'(seq_busy),
          32'(|tab[i].rs));
      chk({name, " done"}, i + 1, 32'(seq_done),
          32'(tab[i].done));
    end
  endtask

  initial begin
    logic [3:0] prev, fell, cur, h1, h2;
    bit         seen;
    rst       = 1'b1;
    rst_req_a = '0;
    repeat (3) tick();
    chk("reset rst_s", 0, 32'(rst_s), 32'hF);
    chk("reset busy", 0, 32'(seq_busy), 32'h1);
    chk("reset done", 0, 32'(seq_done), 32'h0);

    // Power-up with no requests.
    nv = 20;
    for (int i = 0; i < nv; i++) begin
      row(i, 1'b0, 4'b0000, pu(i + 1), (i + 1) == 17);
    end
    run_table("powerup");

    // Request on channel 2, held 3 cycles.
    nv = 18;
    for (int i = 0; i < nv; i++) begin
      int k;
      logic [3:0] rs;
      k  = i + 1;
      rs = (k < 3)  ? 4'b0000 :
           (k < 11) ? 4'b1100 :
           (k < 14) ? 4'b1000 : 4'b0000;
      row(i, 1'b0, (k <= 3) ? 4'b0100 : 4'b0000,
          rs, k == 14);
    end
    run_table("req2");

    // Channel 1 re-requested mid-sequence, racing a release.
    nv = 30;
    for (int i = 0; i < nv; i++) begin
      int k;
      logic [3:0] rs, q;
      k  = i + 1;
      q  = (k == 1)  ? 4'b0001 :
           (k == 13) ? 4'b0010 : 4'b0000;
      rs = (k < 3)  ? 4'b0000 :
           (k < 9)  ? 4'b1111 :
           (k < 12) ? 4'b1110 :
           (k < 15) ? 4'b1100 :
           (k < 21) ? 4'b1110 :
           (k < 24) ? 4'b1100 :
           (k < 27) ? 4'b1000 : 4'b0000;
      row(i, 1'b0, q, rs, k == 27);
    end
    run_table("abort");

    // Channels 3 and 0 together.
    nv = 20;
    for (int i = 0; i < nv; i++) begin
      int k;
      logic [3:0] rs;
      k  = i + 1;
      rs = (k < 3)  ? 4'b0000 :
           (k < 9)  ? 4'b1111 :
           (k < 12) ? 4'b1110 :
           (k < 15) ? 4'b1100 :
           (k < 18) ? 4'b1000 : 4'b0000;
      row(i, 1'b0, (k == 1) ? 4'b1001 : 4'b0000,
          rs, k == 18);
    end
    run_table("req30");

    // rst during WAIT, then full power-up again.
    nv = 32;
    for (int i = 0; i < nv; i++) begin
      int k;
      logic [3:0] rs;
      k  = i + 1;
      rs = (k < 3)  ? 4'b0000 :
           (k < 9)  ? 4'b1111 :
           (k < 10) ? 4'b1110 :
           (k < 12) ? 4'b1111 : pu(k - 11);
      row(i, (k == 10) || (k == 11),
          (k == 1) ? 4'b0001 : 4'b0000,
          rs, k == 28);
    end
    run_table("rstwait");

    // Random request activity with invariant checks.
    h1   = '0;
    h2   = '0;
    prev = rst_s;
    for (int c = 0; c < 3000; c++) begin
      cur = rst_req_a;
      tick();
      chk("rnd busy", c, 32'(seq_busy), 32'(|rst_s));
      fell = prev & ~rst_s;
      if (fell != '0) begin
        chk("rnd onehot", c, 32'(fell & (fell - 4'd1)), 0);
        chk("rnd order", c,
            32'(rst_s & ((fell << 1) - 4'd1)), 0);
        chk("rnd reqfree", c, 32'(h2), 0);
      end
      prev = rst_s;
      h2   = h1;
      h1   = cur;
      #($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) begin
        rst_req_a = '0;
      end else if ($urandom_range(0, 15) == 0) begin
        rst_req_a[$urandom_range(0, 3)] ^= 1'b1;
      end
    end

    // Drain: must reach idle within a bounded time.
    rst_req_a = '0;
    seen      = 1'b0;
    for (int c = 0; c < 200 && !(seen && !seq_busy); c++) begin
      tick();
      if (seq_done) seen = 1'b1;
    end
    chk("drain idle", 0, 32'(rst_s), 0);
    chk("drain done seen", 0, 32'(seen), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
